// File: rtl/s2p_reg.sv
// Serial-to-parallel pair register: groups consecutive samples into (X/I, Y/Q) word pairs.
// Latency: outx/outy/done valid one clock after the second word of a pair is sampled.
// Backpressure: none; a sample is taken on every edge with start=1, and start=0 discards a partial pair.
module s2p_reg #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] serialIn,
    output logic [CNT_W-1:0]  count,
    output logic              done,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] outx,
    output logic [DATA_W-1:0] outy
);

    // 0 = expecting the first word of a pair, 1 = expecting the second word
    logic phase;

    // Capture samples, publish complete pairs, and count every accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
            count <= '0;
            done  <= 1'b0;
            out1  <= '0;
            out2  <= '0;
            outx  <= '0;
            outy  <= '0;
        end else if (start) begin
            // Counter wraps silently; it tracks accepted samples, not pairs
            count <= count + CNT_W'(1);
            if (!phase) begin
                out1  <= serialIn;
                phase <= 1'b1;
                done  <= 1'b0;
            end else begin
                // outy takes serialIn directly so it matches out2 in the same cycle
                out2  <= serialIn;
                outx  <= out1;
                outy  <= serialIn;
                done  <= 1'b1;
                phase <= 1'b0;
            end
        end else begin
            // A gap in start abandons any half-collected pair
            done  <= 1'b0;
            phase <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s2p_reg.sv
// Testbench for s2p_reg: directed vectors with a scoreboard of expected completed pairs.
// Latency: expectations are pushed when the second word is driven and popped on the done strobe.
// Backpressure: none; the monitor also checks done never stays high two cycles in a row.
module tb_s2p_reg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [CNT_W-1:0]  cnt;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] serialIn;
    logic [CNT_W-1:0]  count;
    logic              done;
    logic [DATA_W-1:0] out1, out2, outx, outy;

    s2p_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .serialIn (serialIn),
        .count    (count),
        .done     (done),
        .out1     (out1),
        .out2     (out2),
        .outx     (outx),
        .outy     (outy)
    );

    always #5 clk = ~clk;

    int    checks      = 0;
    int    errors      = 0;
    int    exp_pulses  = 0;
    int    seen_pulses = 0;
    logic  prev_done   = 1'b0;
    pair_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge's worth of inputs, return just after the edge
    task automatic step(input logic r, input logic s, input logic [DATA_W-1:0] d);
        rst      = r;
        start    = s;
        serialIn = d;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                        input logic [CNT_W-1:0] c);
        pair_t p;
        p.x = x;
        p.y = y;
        p.cnt = c;
        sb_q.push_back(p);
        exp_pulses++;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_out1"},  32'(out1),  32'd0);
        chk({tag, "_out2"},  32'(out2),  32'd0);
        chk({tag, "_outx"},  32'(outx),  32'd0);
        chk({tag, "_outy"},  32'(outy),  32'd0);
    endtask

    function automatic logic [DATA_W-1:0] wrap_word(input int i);
        return DATA_W'(i * 257);
    endfunction

    // Monitor: on every done strobe, compare against the oldest expected pair
    always @(negedge clk) begin
        if (done) begin
            pair_t e;
            seen_pulses++;
            chk("done_not_back_to_back", 32'(prev_done), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending pair at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("pair_outx",  32'(outx),  32'(e.x));
                chk("pair_outy",  32'(outy),  32'(e.y));
                chk("pair_out1",  32'(out1),  32'(e.x));
                chk("pair_out2",  32'(out2),  32'(e.y));
                chk("pair_count", 32'(count), 32'(e.cnt));
            end
        end
        prev_done = done;
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        serialIn = '0;

        // Reset with arbitrary inputs for two edges
        step(1'b1, 1'b1, 16'hFFFF);
        step(1'b1, 1'b1, 16'hA5A5);
        check_cleared("reset");

        // Single pair
        step(1'b0, 1'b1, 16'h0800);
        chk("pair1_out1_first", 32'(out1), 32'h0800);
        chk("pair1_done_after_first", 32'(done), 32'd0);
        push(16'h0800, 16'h1000, 5'd2);
        step(1'b0, 1'b1, 16'h1000);
        step(1'b0, 1'b0, 16'h0000);
        chk("pair1_done_cleared", 32'(done), 32'd0);
        chk("pair1_count_hold", 32'(count), 32'd2);

        // Back-to-back stream of three pairs
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0800);
        push(16'h0800, 16'h1000, 5'd2);
        step(1'b0, 1'b1, 16'h1000);
        step(1'b0, 1'b1, 16'h1800);
        push(16'h1800, 16'h2000, 5'd4);
        step(1'b0, 1'b1, 16'h2000);
        step(1'b0, 1'b1, 16'h2800);
        push(16'h2800, 16'h3000, 5'd6);
        step(1'b0, 1'b1, 16'h3000);
        step(1'b0, 1'b0, 16'h0000);
        chk("stream_count", 32'(count), 32'd6);
        chk("stream_pulses", 32'(seen_pulses), 32'(exp_pulses));

        // Abort: start gap discards the half pair
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h1800);
        step(1'b0, 1'b0, 16'hDEAD);
        chk("abort_count_hold", 32'(count), 32'd1);
        chk("abort_out1_hold",  32'(out1),  32'h1800);
        step(1'b0, 1'b1, 16'h2000);
        push(16'h2000, 16'h2800, 5'd3);
        step(1'b0, 1'b1, 16'h2800);
        step(1'b0, 1'b0, 16'h0000);
        chk("abort_count", 32'(count), 32'd3);

        // Counter wrap over 33 words
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 1; i <= 33; i++) begin
            if (i % 2 == 0)
                push(wrap_word(i - 1), wrap_word(i), CNT_W'(i % 32));
            step(1'b0, 1'b1, wrap_word(i));
        end
        chk("wrap_count", 32'(count), 32'd1);
        chk("wrap_done_low", 32'(done), 32'd0);
        step(1'b0, 1'b0, 16'h0000);

        // Reset in the middle of a pair
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0800);
        step(1'b1, 1'b1, 16'h5555);
        check_cleared("midreset");
        step(1'b0, 1'b1, 16'h1000);
        push(16'h1000, 16'h1800, 5'd2);
        step(1'b0, 1'b1, 16'h1800);
        step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("total_pulses", 32'(seen_pulses), 32'(exp_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
